pdm_mic_ctrl: RTL
=================

PDM_MIC_CTRL -- requirements
Module: pdm_mic_ctrl

Interface
REQ-001 SHALL have parameter DIV_HALF, default 20, giving clk cycles per pdm_clk half-period (120 MHz / 40 = 3 MHz); legal range 2..255.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4096, giving pdm_clk periods discarded after start; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: system clock (120 MHz PLL global clock); the block's only clock.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pll_locked, input, 1 bit: PLL lock status, synchronous to clk.
REQ-006 SHALL have port enable, input, 1 bit: request to run the microphone.
REQ-007 SHALL have port pdm_dat, input, 1 bit: microphone data.
REQ-008 SHALL have port pdm_clk, output, 1 bit: microphone clock, registered.
REQ-009 SHALL have port bit_data, output, 1 bit: captured PDM bit.
REQ-010 SHALL have port bit_valid, output, 1 bit: bit_data is valid.
REQ-011 SHALL have port bit_ready, input, 1 bit: consumer accepts bit_data.
REQ-012 SHALL have port running, output, 1 bit: high only in state RUN.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a captured bit was dropped.

Function
REQ-014 SHALL implement states IDLE, WAIT_LOCK, SETTLE, RUN, STOP.
REQ-015 IDLE -> WAIT_LOCK SHALL occur when enable=1; WAIT_LOCK -> SETTLE SHALL occur when pll_locked=1.
REQ-016 In SETTLE and RUN, pdm_clk SHALL toggle when the divider reaches DIV_HALF-1, after which the divider returns to 0.
REQ-017 In IDLE and WAIT_LOCK, pdm_clk SHALL be held at 0 and the divider at 0.
REQ-018 The settle counter SHALL count pdm_clk rising transitions in SETTLE; on reaching SETTLE_CYCLES the block SHALL enter RUN, with no bits emitted during SETTLE.
REQ-019 In RUN, pdm_dat SHALL be captured in the clk cycle in which pdm_clk is driven 0->1, i.e. sampled before the new rising edge.
REQ-020 A capture SHALL load bit_data and set bit_valid on the next cycle, giving 1 clk of latency.
REQ-021 bit_valid SHALL stay high with bit_data stable until a cycle with bit_ready=1; it SHALL then clear unless a new capture lands in the same cycle.
REQ-022 If a capture occurs while bit_valid=1 and bit_ready=0, the new bit SHALL be dropped, the old bit SHALL be kept, and overrun SHALL be set.
REQ-023 If a capture coincides with bit_valid=1 and bit_ready=1, the block SHALL load the new bit, keep bit_valid high, and leave overrun unchanged.
REQ-024 If enable=0 in SETTLE or RUN, the block SHALL enter STOP.
REQ-025 In STOP, the divider SHALL run until pdm_clk is 0 at a toggle point, then hold pdm_clk at 0 and go to IDLE, with no new captures.
REQ-026 If enable returns to 1 during STOP, STOP SHALL still complete to IDLE.
REQ-027 In IDLE, a pending bit_valid SHALL still drain via bit_ready.
REQ-028 If pll_locked=0 in SETTLE, RUN or STOP, the block SHALL go to WAIT_LOCK immediately, force pdm_clk=0, clear the divider and the settle counter, and clear bit_valid.
REQ-029 overrun SHALL clear only on reset or on the IDLE -> WAIT_LOCK transition.

Reset
REQ-030 While rst_n=0, the block SHALL force state=IDLE, pdm_clk=0, bit_data=0, bit_valid=0, running=0, overrun=0, and clear all counters.
REQ-031 Reset assertion SHALL take effect asynchronously, including mid-RUN; release SHALL be synchronous to clk, with the first transition no earlier than the first clk edge after release.

Configuration
REQ-032 Macro PDM_MIC_STEREO_EN SHALL enable stereo operation.
REQ-033 When PDM_MIC_STEREO_EN is defined, the block SHALL capture on both pdm_clk transitions: the 0->1 toggle gives channel 0 and the 1->0 toggle gives channel 1.
REQ-034 When PDM_MIC_STEREO_EN is defined, the block SHALL add output bit_chan (1 bit) that follows bit_data under the same valid/ready and overrun rules.
REQ-035 When PDM_MIC_STEREO_EN is undefined, the block SHALL have no bit_chan port and SHALL behave as REQ-019.

Verification
REQ-036 The bench SHALL hold pll_locked=1, enable=1, SETTLE_CYCLES=4, and bit_ready=1 -> pdm_clk period = 40 clk, first bit_valid after the 4th rising transition plus one period, one bit every 40 clk.
REQ-037 The bench SHALL drive pdm_dat with pattern 1,0,1,1 at the capture cycles with bit_ready=1 -> bit_data sequence 1,0,1,1, each bit_valid pulse 1 clk wide.
REQ-038 The bench SHALL hold bit_ready=0 for 2 capture periods -> first bit held, overrun=1 after the second capture; overrun stays set after bit_ready=1 until enable toggles through IDLE.
REQ-039 The bench SHALL drop pll_locked for 1 clk in RUN -> next cycle state WAIT_LOCK, pdm_clk=0, bit_valid=0, full settle repeated after relock.
REQ-040 The bench SHALL set enable=0 mid-RUN while pdm_clk=1 -> pdm_clk falls at the next toggle point, then stays 0, running=0, no further bit_valid.
REQ-041 The bench SHALL assert rst_n=0 asynchronously mid-RUN with bit_valid=1 -> all outputs 0 within the same cycle, IDLE after release.

Source files
------------

// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: PDM microphone clock generator and bit capture with valid/ready output.
// Define PDM_MIC_STEREO_EN to capture on both pdm_clk edges and add the bit_chan output.
module pdm_mic_ctrl #(
   parameter int DIV_HALF      = 20,
   parameter int SETTLE_CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_locked,
   input  logic enable,
   input  logic pdm_dat,
   output logic pdm_clk,
   output logic bit_data,
   output logic bit_valid,
   input  logic bit_ready,
   output logic running,
`ifdef PDM_MIC_STEREO_EN
   output logic bit_chan,
`endif
   output logic overrun
);
   localparam logic [7:0]  DIV_LAST = 8'(DIV_HALF - 1);
   localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WAIT_LOCK, SETTLE, RUN, STOP} state_t;
   state_t state, state_nx;
   logic [7:0]  div;
   logic [15:0] cnt;
   logic active, tick, rise, lose, cap;

   assign active = (state == SETTLE) || (state == RUN) || (state == STOP);
   assign tick   = active && (div == DIV_LAST);
   assign rise   = tick && !pdm_clk;
   assign lose   = active && !pll_locked;
`ifdef PDM_MIC_STEREO_EN
   assign cap    = (state == RUN) && tick;
`else
   assign cap    = (state == RUN) && rise;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = enable ? WAIT_LOCK : IDLE;
         WAIT_LOCK: state_nx = pll_locked ? SETTLE : WAIT_LOCK;
         SETTLE:    state_nx = !pll_locked ? WAIT_LOCK : !enable ? STOP :
                               (rise && cnt == SET_LAST) ? RUN : SETTLE;
         RUN:       state_nx = !pll_locked ? WAIT_LOCK : !enable ? STOP : RUN;
         STOP:      state_nx = !pll_locked ? WAIT_LOCK : tick ? IDLE : STOP;
         default:   state_nx = IDLE;
      endcase
   end

   always_comb running = (state == RUN);

   // STOP only ever drives pdm_clk low at a toggle point, so the mic never sees a runt pulse
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         div     <= '0;
         cnt     <= '0;
         pdm_clk <= 1'b0;
      end else if (!active || lose) begin
         div     <= '0;
         cnt     <= '0;
         pdm_clk <= 1'b0;
      end else begin
         div <= tick ? 8'd0 : div + 8'd1;
         if (tick) pdm_clk <= (state == STOP) ? 1'b0 : !pdm_clk;
         if (state == SETTLE && rise) cnt <= cnt + 16'd1;
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bit_data  <= 1'b0;
         bit_valid <= 1'b0;
         overrun   <= 1'b0;
`ifdef PDM_MIC_STEREO_EN
         bit_chan  <= 1'b0;
`endif
      end else begin
         if (state == IDLE && enable) overrun <= 1'b0;
         if (lose) bit_valid <= 1'b0;
         else if (cap && (!bit_valid || bit_ready)) begin
            bit_data  <= pdm_dat;
            bit_valid <= 1'b1;
`ifdef PDM_MIC_STEREO_EN
            bit_chan  <= pdm_clk;
`endif
         end else if (cap) overrun <= 1'b1;
         else if (bit_ready) bit_valid <= 1'b0;
      end
endmodule
